// File: rtl/fetch_prefetch_queue_if.sv
// Fetch queue bundle: ROM request/return port, redirect/halt
// controls and the decode-side valid/ready handshake.
interface fetch_prefetch_queue_if #(
    parameter int PC_W    = 12,
    parameter int INSTR_W = 15,
    parameter int DEPTH   = 4
);
    localparam int OW = $clog2(DEPTH + 1);

    logic [PC_W-1:0]    rom_addr;
    logic               rom_req;
    logic [INSTR_W-1:0] rom_data;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               halt_i;
    logic               instr_ready;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic [OW-1:0]      occupancy;

    modport master (
        output rom_addr, rom_req,
        output instr_valid, instr, instr_pc, occupancy,
        input  rom_data, redirect_valid, redirect_pc,
        input  halt_i, instr_ready
    );

    modport slave (
        input  rom_addr, rom_req,
        input  instr_valid, instr, instr_pc, occupancy,
        output rom_data, redirect_valid, redirect_pc,
        output halt_i, instr_ready
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Prefetching fetch stage: sequential PC issue to a fixed-latency
// ROM, return FIFO towards decode, redirect flush and halt.
module fetch_prefetch_queue #(
    parameter int              PC_W     = 12,
    parameter int              INSTR_W  = 15,
    parameter int              DEPTH    = 4,
    parameter int              ROM_LAT  = 1,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'('o4000)
) (
    input logic                    clock,
    input logic                    reset_n,
    fetch_prefetch_queue_if.master bus
);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int IW = $clog2(ROM_LAT + 1);
    localparam int CW = 8;

    logic [PC_W-1:0]    fetch_pc;
    logic [ROM_LAT-1:0] sr_vld;
    logic [PC_W-1:0]    sr_pc [ROM_LAT];
    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [PC_W-1:0]    mem_pc [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [OW-1:0]      occ;
    logic [IW-1:0]      inflight;
    logic               credit;
    logic               req;
    logic               push;
    logic               pop;
    logic [PC_W-1:0]    req_pc;
    logic               head_valid;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Count outstanding ROM reads still travelling down the pipe
    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            inflight = inflight + IW'(sr_vld[i]);
        end
    end

    // Pops are not credited: issue only when the FIFO can absorb
    // every read already outstanding plus this one.
    assign credit = (CW'(occ) + CW'(inflight)) < CW'(DEPTH);
    // A redirect bypasses the credit check since it empties the FIFO
    assign req = reset_n && !bus.halt_i &&
                 (bus.redirect_valid || credit);
    assign req_pc = bus.redirect_valid ? bus.redirect_pc : fetch_pc;
    assign head_valid = (occ != '0);
    assign push = sr_vld[ROM_LAT-1] && !bus.redirect_valid;
    assign pop = head_valid && bus.instr_ready && !bus.redirect_valid;

    // Next sequential fetch address, reloaded on redirect
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            fetch_pc <= bus.halt_i ? bus.redirect_pc
                                   : bus.redirect_pc + PC_W'(1);
        end else if (req) begin
            fetch_pc <= fetch_pc + PC_W'(1);
        end
    end

    // Request shift register tracking PCs of outstanding reads
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr_vld <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                sr_pc[i] <= '0;
            end
        end else begin
            if (bus.redirect_valid) begin
                sr_vld <= ROM_LAT'(req);
            end else begin
                sr_vld <= (sr_vld << 1) | ROM_LAT'(req);
            end
            sr_pc[0] <= req_pc;
            for (int i = 1; i < ROM_LAT; i++) begin
                sr_pc[i] <= sr_pc[i-1];
            end
        end
    end

    // Return FIFO: push returning words, pop to decode, flush on redirect
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else if (bus.redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem_instr[wr_ptr] <= bus.rom_data;
                mem_pc[wr_ptr]    <= sr_pc[ROM_LAT-1];
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    assert property (@(posedge clock) disable iff (!reset_n)
        !(push && occ == OW'(DEPTH)));

    assign bus.rom_req     = req;
    assign bus.rom_addr    = req_pc;
    assign bus.instr_valid = head_valid;
    assign bus.instr       = head_valid ? mem_instr[rd_ptr] : '0;
    assign bus.instr_pc    = head_valid ? mem_pc[rd_ptr] : '0;
    assign bus.occupancy   = occ;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: one instance with
// ROM_LAT=1/DEPTH=4 and one with ROM_LAT=3/DEPTH=5.
module tb_fetch_prefetch_queue;
    localparam int PC_W    = 12;
    localparam int INSTR_W = 15;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   vectors;
    int   miscompares;

    always #5 clk = ~clk;

    fetch_prefetch_queue_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(4)) bus_a ();
    fetch_prefetch_queue_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(5)) bus_b ();

    fetch_prefetch_queue #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(4),
        .ROM_LAT(1), .RESET_PC(12'o4000)
    ) dut_a (
        .clock(clk), .reset_n(rst_a), .bus(bus_a)
    );

    fetch_prefetch_queue #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(5),
        .ROM_LAT(3), .RESET_PC(12'o4000)
    ) dut_b (
        .clock(clk), .reset_n(rst_b), .bus(bus_b)
    );

    // ROM models: word content equals its address
    logic [PC_W-1:0] pa;
    logic [PC_W-1:0] pb [3];

    always @(posedge clk) begin
        pa    <= bus_a.rom_addr;
        pb[0] <= bus_b.rom_addr;
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end

    assign bus_a.rom_data = INSTR_W'(pa);
    assign bus_b.rom_data = INSTR_W'(pb[2]);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0o want %0o", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.halt_i = 1'b0;
        bus_a.redirect_valid = 1'b0;
        bus_a.redirect_pc = '0;
        bus_a.instr_ready = 1'b1;
        bus_b.halt_i = 1'b0;
        bus_b.redirect_valid = 1'b0;
        bus_b.redirect_pc = '0;
        bus_b.instr_ready = 1'b1;
        nxt();
        nxt();
        #1;
        chk("rst_valid", 32'(bus_a.instr_valid), 0);
        chk("rst_occ", 32'(bus_a.occupancy), 0);
        chk("rst_req", 32'(bus_a.rom_req), 0);
        chk("rst_instr", 32'(bus_a.instr), 0);
        chk("rst_pc", 32'(bus_a.instr_pc), 0);

        // Streaming after reset release
        for (int k = 0; k < 8; k++) begin
            nxt();
            if (k == 0) rst_a = 1'b1;
            #1;
            chk("t1_req", 32'(bus_a.rom_req), 1);
            chk("t1_addr", 32'(bus_a.rom_addr), 'o4000 + k);
            if (k < 2) begin
                chk("t1_vld_lo", 32'(bus_a.instr_valid), 0);
            end else begin
                chk("t1_vld", 32'(bus_a.instr_valid), 1);
                chk("t1_pc", 32'(bus_a.instr_pc), 'o4000 + k - 2);
                chk("t1_instr", 32'(bus_a.instr), 'o4000 + k - 2);
            end
        end

        // Decode stall fills the FIFO, then drains in order
        nxt();
        rst_a = 1'b0;
        bus_a.instr_ready = 1'b0;
        nxt();
        for (int k = 0; k < 16; k++) begin
            nxt();
            if (k == 0) rst_a = 1'b1;
            if (k == 10) bus_a.instr_ready = 1'b1;
            #1;
            if (k == 3) chk("t2_req3", 32'(bus_a.rom_req), 1);
            if (k == 4) chk("t2_req_drop", 32'(bus_a.rom_req), 0);
            if (k >= 2 && k < 10) begin
                chk("t2_head", 32'(bus_a.instr_pc), 'o4000);
            end
            if (k == 9) begin
                chk("t2_occ_full", 32'(bus_a.occupancy), 4);
                chk("t2_req_full", 32'(bus_a.rom_req), 0);
            end
            if (k == 10) chk("t2_req_pop", 32'(bus_a.rom_req), 0);
            if (k == 11) chk("t2_addr_resume", 32'(bus_a.rom_addr), 'o4004);
            if (k >= 10) begin
                chk("t2_drain_vld", 32'(bus_a.instr_valid), 1);
                chk("t2_drain_pc", 32'(bus_a.instr_pc), 'o4000 + k - 10);
            end
        end

        // Redirect with occupancy 3 and one read in flight, then wrap
        nxt();
        rst_a = 1'b0;
        bus_a.instr_ready = 1'b0;
        nxt();
        for (int k = 0; k < 12; k++) begin
            nxt();
            if (k == 0) rst_a = 1'b1;
            if (k == 4) begin
                bus_a.redirect_valid = 1'b1;
                bus_a.redirect_pc = 12'o2000;
            end
            if (k == 5) begin
                bus_a.redirect_valid = 1'b0;
                bus_a.instr_ready = 1'b1;
            end
            if (k == 8) begin
                bus_a.redirect_valid = 1'b1;
                bus_a.redirect_pc = 12'o7777;
            end
            if (k == 9) bus_a.redirect_valid = 1'b0;
            #1;
            if (k == 4) begin
                chk("t3_occ_pre", 32'(bus_a.occupancy), 3);
                chk("t3_req", 32'(bus_a.rom_req), 1);
                chk("t3_addr", 32'(bus_a.rom_addr), 'o2000);
            end
            if (k == 5) begin
                chk("t3_occ_clr", 32'(bus_a.occupancy), 0);
                chk("t3_vld_clr", 32'(bus_a.instr_valid), 0);
                chk("t3_addr_nxt", 32'(bus_a.rom_addr), 'o2001);
            end
            if (k == 6) begin
                chk("t3_vld", 32'(bus_a.instr_valid), 1);
                chk("t3_pc0", 32'(bus_a.instr_pc), 'o2000);
            end
            if (k == 7) chk("t3_pc1", 32'(bus_a.instr_pc), 'o2001);
            if (k == 8) chk("t4_addr", 32'(bus_a.rom_addr), 'o7777);
            if (k == 9) begin
                chk("t4_req_wrap", 32'(bus_a.rom_req), 1);
                chk("t4_addr_wrap", 32'(bus_a.rom_addr), 0);
            end
            if (k == 10) chk("t4_pc_top", 32'(bus_a.instr_pc), 'o7777);
            if (k == 11) begin
                chk("t4_vld_wrap", 32'(bus_a.instr_valid), 1);
                chk("t4_pc_wrap", 32'(bus_a.instr_pc), 0);
            end
        end

        // Halt with one read in flight
        nxt();
        rst_a = 1'b0;
        bus_a.instr_ready = 1'b1;
        nxt();
        for (int k = 0; k < 9; k++) begin
            nxt();
            if (k == 0) rst_a = 1'b1;
            if (k == 1) bus_a.halt_i = 1'b1;
            if (k == 6) bus_a.halt_i = 1'b0;
            #1;
            if (k == 0) chk("t5_addr0", 32'(bus_a.rom_addr), 'o4000);
            if (k >= 1 && k <= 5) chk("t5_req_halt", 32'(bus_a.rom_req), 0);
            if (k == 2) begin
                chk("t5_vld", 32'(bus_a.instr_valid), 1);
                chk("t5_pc", 32'(bus_a.instr_pc), 'o4000);
            end
            if (k == 4) chk("t5_drained", 32'(bus_a.instr_valid), 0);
            if (k == 6) begin
                chk("t5_req_resume", 32'(bus_a.rom_req), 1);
                chk("t5_addr_resume", 32'(bus_a.rom_addr), 'o4001);
            end
            if (k == 8) chk("t5_pc_resume", 32'(bus_a.instr_pc), 'o4001);
        end

        // ROM_LAT=3, DEPTH=5 streaming
        for (int k = 0; k < 10; k++) begin
            nxt();
            if (k == 0) rst_b = 1'b1;
            #1;
            chk("t6_req", 32'(bus_b.rom_req), 1);
            chk("t6_addr", 32'(bus_b.rom_addr), 'o4000 + k);
            if (k == 3) chk("t6_vld_lo", 32'(bus_b.instr_valid), 0);
            if (k >= 4) begin
                chk("t6_vld", 32'(bus_b.instr_valid), 1);
                chk("t6_pc", 32'(bus_b.instr_pc), 'o4000 + k - 4);
            end
        end

        // Mid-stream reset pulse
        nxt();
        rst_b = 1'b0;
        #1;
        chk("t6_rst_occ", 32'(bus_b.occupancy), 0);
        chk("t6_rst_vld", 32'(bus_b.instr_valid), 0);
        chk("t6_rst_req", 32'(bus_b.rom_req), 0);
        for (int d = 0; d < 5; d++) begin
            nxt();
            if (d == 0) rst_b = 1'b1;
            #1;
            if (d == 0) chk("t6_addr_rst", 32'(bus_b.rom_addr), 'o4000);
            if (d < 4) chk("t6_stale_vld", 32'(bus_b.instr_valid), 0);
            if (d == 4) begin
                chk("t6_vld_rst", 32'(bus_b.instr_valid), 1);
                chk("t6_pc_rst", 32'(bus_b.instr_pc), 'o4000);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Parametrised successor to the single-PC-register fetch stage of the pipelined core.
- Generates sequential instruction addresses and issues them to a synchronous ROM port with configurable read latency.
- Buffers returned instruction words with their PCs in a DEPTH-entry FIFO and presents them to decode through a valid/ready handshake.
- Branch redirect flushes both the FIFO and in-flight ROM reads. Halt freezes issue.

Parameters:
PC_W, 12, width of PC and ROM address
INSTR_W, 15, instruction word width
DEPTH, 4, FIFO entries (2..16)
ROM_LAT, 1, ROM read latency in cycles (1..3)
RESET_PC, 'o4000, PC loaded on reset

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
rom_addr  out  PC_W  ROM fetch address
rom_req  out  1  address valid this cycle
rom_data  in  INSTR_W  ROM word, valid ROM_LAT cycles after its request
redirect_valid  in  1  branch taken; load redirect_pc
redirect_pc  in  PC_W  branch target
halt_i  in  1  stop issuing new fetches
instr_ready  in  1  decode can accept (deasserted on decode stall)
instr_valid  out  1  FIFO head valid
instr  out  INSTR_W  FIFO head word
instr_pc  out  PC_W  PC of FIFO head
occupancy  out  $clog2(DEPTH+1)  entries currently held

Behaviour:
- Reset (asynchronous, reset_n=0):
  - fetch_pc=RESET_PC; FIFO empty; all in-flight valid bits 0.
  - instr_valid=0, instr=0, instr_pc=0, occupancy=0, rom_req=0.
- Issue condition: issue = !halt_i && (occupancy + inflight < DEPTH), where inflight = number of set bits in the ROM_LAT-deep request shift register.
  - A pop in the same cycle is not credited, so issue is conservative.
  - Full throughput of 1 instr/cycle is reached when DEPTH >= ROM_LAT+2.
- Normal cycle:
  - rom_req=issue; rom_addr=fetch_pc.
  - On issue, fetch_pc <= fetch_pc+1, wrapping modulo 2^PC_W (all-ones -> 0).
  - Each issued PC enters the request shift register with a valid bit.
- Return: when a valid shift-register entry reaches stage ROM_LAT, {rom_data, pc} is pushed into the FIFO at that clock edge.
  - The issue rule guarantees the push never overflows. Assertion: push while full is an error.
- Output: instr_valid = (occupancy != 0). instr and instr_pc are the FIFO head, driven from registered state only, with no combinational path from any input.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle leaves occupancy unchanged.
- Minimum latency: request in cycle n -> instr_valid in cycle n+ROM_LAT+1.
- Redirect (redirect_valid=1 in cycle n):
  - rom_req=1, rom_addr=redirect_pc in cycle n, regardless of the credit check, because the FIFO is cleared. halt_i still suppresses rom_req.
  - At the edge: FIFO cleared (occupancy <= 0); all older in-flight valid bits cleared; only the cycle-n request survives.
  - fetch_pc <= redirect_pc+1 (wrapping), or <= redirect_pc if halted.
  - A pop coincident with a redirect is discarded; the clear dominates.
  - The first valid instruction after a redirect appears in cycle n+ROM_LAT+1 with instr_pc=redirect_pc.
- Halt:
  - halt_i=1 -> rom_req=0; in-flight reads still complete and are pushed; FIFO drains normally.
  - Deasserting halt_i resumes issue at the held fetch_pc.
- Reset mid-operation: all in-flight reads are abandoned. ROM data arriving after reset release is ignored because its valid bits are 0.
- Wrap: FIFO read/write pointers wrap modulo DEPTH. Non-power-of-2 DEPTH is supported via explicit compare-and-reset.
- Stall: instr_ready=0 indefinitely -> FIFO fills to DEPTH, then rom_req=0. Once full, instr/instr_pc remain stable while instr_valid=1 and instr_ready=0.

Test Plan:
- Reset release, ROM_LAT=1, instr_ready=1, ROM returns data=addr -> rom_addr 'o4000,'o4001,... on consecutive cycles. instr_valid first high 2 cycles after the first request, with instr_pc='o4000, then one instruction per cycle with no bubbles.
- instr_ready held 0 for 10 cycles, DEPTH=4 -> occupancy saturates at 4 and rom_req drops. Head stays at pc 'o4000. Releasing ready delivers 'o4000..'o4003 in order with no loss or duplication.
- Redirect to 'o2000 while occupancy=3 and one read in flight -> next cycle occupancy=0. The stale in-flight word is never output. Next instr_pc is 'o2000, followed by 'o2001.
- fetch_pc at 'o7777 -> next rom_addr is 0. instr_pc sequence is 'o7777, 0.
- halt_i asserted for 5 cycles with 1 read in flight -> the in-flight word is delivered, rom_req=0 throughout, and issue resumes at the next sequential PC after release.
- ROM_LAT=3, DEPTH=5 -> steady-state throughput 1/cycle. reset_n pulsed low mid-stream -> occupancy=0 immediately; the first output after release has instr_pc='o4000.
